// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster timing generator: position counters, sync/blank decode,
//            pixel/frame/vblank strobes and a frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        pixel_en,
    output logic        frame_start,
    output logic        vblank_start,
    output logic [7:0]  frame_count
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] c_H_LAST     = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0]  c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  c_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  c_DIV_LAST   = 4'(PIX_DIV - 1);

    logic [3:0]  r_div;
    logic [10:0] r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic        r_pixel_en;
    logic        r_frame_start;
    logic        r_vblank_start;
    logic [7:0]  r_frame_count;

    logic        w_tick;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [10:0] w_h_next;
    logic [9:0]  w_v_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_blank_next;
    logic        w_frame_next;
    logic        w_vblank_next;

    // All decode works on the next position so it lands in the same
    // register stage as the position itself.
    always_comb begin
        w_tick        = run && (r_div == c_DIV_LAST);
        w_h_wrap      = (r_hcount == c_H_LAST);
        w_v_wrap      = w_h_wrap && (r_vcount == c_V_LAST);
        w_h_next      = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_v_next      = r_vcount;
        if (w_v_wrap) begin
            w_v_next = 10'd0;
        end else if (w_h_wrap) begin
            w_v_next = r_vcount + 10'd1;
        end
        w_hsync_next  = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
        w_vsync_next  = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
        w_blank_next  = (w_h_next >= c_H_ACT) || (w_v_next >= c_V_ACT);
        w_frame_next  = (w_h_next == 11'd0) && (w_v_next == 10'd0);
        w_vblank_next = (w_h_next == 11'd0) && (w_v_next == c_V_ACT);
    end

    // Divider freezes while run is low so a resume picks up mid-pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 4'd0;
        end else if (run) begin
            r_div <= (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount       <= 11'd0;
            r_vcount       <= 10'd0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_blank        <= 1'b0;
            r_pixel_en     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_count  <= 8'd0;
        end else if (w_tick) begin
            r_hcount       <= w_h_next;
            r_vcount       <= w_v_next;
            r_hsync        <= w_hsync_next;
            r_vsync        <= w_vsync_next;
            r_blank        <= w_blank_next;
            r_pixel_en     <= 1'b1;
            r_frame_start  <= w_frame_next;
            r_vblank_start <= w_vblank_next;
            if (w_frame_next) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end else begin
            r_pixel_en     <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end
    end

    assign hcount       = r_hcount;
    assign vcount       = r_vcount;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign blank        = r_blank;
    assign pixel_en     = r_pixel_en;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;
    assign frame_count  = r_frame_count;

endmodule
`default_nettype wire
